sram_arbiter: RTL

//  Shares one external asynchronous SRAM between two requesters: port 0 is the

---
 rtl/sram_arbiter.sv | 289 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
//
// Shares one external asynchronous SRAM between two requesters.
//   port 0 : UART-RX byte writer
//   port 1 : readback / dump engine
// One port is granted at a time. Each access runs through fixed phases:
//   IDLE -> SETUP (1 clk) -> ACCESS (WAIT_CYCLES clks) -> HOLD (1 clk) -> IDLE
// The granted port's ACK is high for the single HOLD cycle. Read data is
// captured on the last ACCESS edge, so RDATA is valid together with ACK.
// All SRAM-facing outputs come straight from flops, so the strobes are
// glitch-free at the pads.
//
// Configuration macro:
//   SRAM_ARB_FIXED_PRIO_EN  defined     : port 0 wins every tie; no
//                                         last-grant state exists.
//                           undefined   : round-robin. On a tie the port
//                                         that was not granted last wins.
//                                         Port 0 wins the first tie after
//                                         reset.
//
// Parameters:
//   ADDR_W       SRAM address width
//   DATA_W       SRAM data width
//   WAIT_CYCLES  ACCESS phase length in clocks (>= 1; 0 is not supported)
//
// Ports:
//   CLK_IN        in   system clock
//   RST_IN        in   asynchronous reset, active-high. It aborts an
//                      access in flight and issues no ACK.
//   REQn_i        in   port n request; held high until ACKn_o
//   WEn_i         in   port n command: 1 = write, 0 = read
//   ADDRn_i       in   port n address
//   WDATAn_i      in   port n write data
//   ACKn_o        out  port n access complete (one-cycle pulse)
//   RDATAn_o      out  port n read data. It is valid with ACKn_o and held
//                      until the next read on that port.
//   SRAM_ADDR_o   out  SRAM address
//   SRAM_DQ_o     out  data driven to the SRAM
//   SRAM_DQ_i     in   data read from the SRAM
//   SRAM_DQ_OE_o  out  1 = FPGA drives DQ (the tristate buffer lives in top)
//   SRAM_CE_N_o, SRAM_WE_N_o, SRAM_OE_N_o   out  active-low strobes
// ---------------------------------------------------------------------------
module sram_arbiter #(
   parameter int ADDR_W      = 18,
   parameter int DATA_W      = 16,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              CLK_IN,
   input  logic              RST_IN,
   // port 0
   input  logic              REQ0_i,
   input  logic              WE0_i,
   input  logic [ADDR_W-1:0] ADDR0_i,
   input  logic [DATA_W-1:0] WDATA0_i,
   output logic              ACK0_o,
   output logic [DATA_W-1:0] RDATA0_o,
   // port 1
   input  logic              REQ1_i,
   input  logic              WE1_i,
   input  logic [ADDR_W-1:0] ADDR1_i,
   input  logic [DATA_W-1:0] WDATA1_i,
   output logic              ACK1_o,
   output logic [DATA_W-1:0] RDATA1_o,
   // SRAM pads
   output logic [ADDR_W-1:0] SRAM_ADDR_o,
   output logic [DATA_W-1:0] SRAM_DQ_o,
   input  logic [DATA_W-1:0] SRAM_DQ_i,
   output logic              SRAM_DQ_OE_o,
   output logic              SRAM_CE_N_o,
   output logic              SRAM_WE_N_o,
   output logic              SRAM_OE_N_o
);

   // The counter only has to hold WAIT_CYCLES-1.
   localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_HOLD   = 2'd3
   } state_t;

   state_t            state_r, state_s;
   logic [CNT_W-1:0]  cnt_r, cnt_s;
   logic              port_r, port_s;      // granted port: 0 or 1
   logic              we_r, we_s;          // command latched at grant
   logic [ADDR_W-1:0] addr_r, addr_s;
   logic [DATA_W-1:0] wdata_r, wdata_s;
   logic              ack0_r, ack0_s;
   logic              ack1_r, ack1_s;
   logic [DATA_W-1:0] rdata0_r, rdata0_s;
   logic [DATA_W-1:0] rdata1_r, rdata1_s;
   logic              ce_n_r, ce_n_s;
   logic              we_n_r, we_n_s;
   logic              oe_n_r, oe_n_s;
   logic              dq_oe_r, dq_oe_s;
   logic              any_req_s;
   logic              pick1_s;             // 1 = port 1 wins this IDLE cycle

   assign any_req_s = REQ0_i | REQ1_i;

`ifdef SRAM_ARB_FIXED_PRIO_EN
   // Fixed priority: port 1 is granted only when port 0 is not requesting.
   always_comb begin
      pick1_s = REQ1_i & ~REQ0_i;
   end
`else
   logic last_grant_r;                     // port granted most recently

   // Round-robin pick: on a tie, the port that was not granted last wins.
   always_comb begin
      if (REQ0_i && REQ1_i) begin
         pick1_s = ~last_grant_r;
      end else begin
         pick1_s = REQ1_i;
      end
   end

   // Last-grant tracker. Reset value 1 makes port 0 win the first tie.
   always_ff @(posedge CLK_IN or posedge RST_IN) begin
      if (RST_IN) begin
         last_grant_r <= 1'b1;
      end else if ((state_r == ST_IDLE) && any_req_s) begin
         last_grant_r <= pick1_s;
      end
   end
`endif

   // FSM state register.
   always_ff @(posedge CLK_IN or posedge RST_IN) begin
      if (RST_IN) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state, command latch, ACK/RDATA, and strobe levels for the next
   // state. These values are registered below, so every pad output is a flop.
   always_comb begin
      state_s  = state_r;
      cnt_s    = cnt_r;
      port_s   = port_r;
      we_s     = we_r;
      addr_s   = addr_r;
      wdata_s  = wdata_r;
      ack0_s   = 1'b0;
      ack1_s   = 1'b0;
      rdata0_s = rdata0_r;
      rdata1_s = rdata1_r;

      case (state_r)
         ST_IDLE: begin
            if (any_req_s) begin
               // Latch the winner's command. Inputs are ignored until the
               // next grant.
               port_s = pick1_s;
               if (pick1_s) begin
                  we_s    = WE1_i;
                  addr_s  = ADDR1_i;
                  wdata_s = WDATA1_i;
               end else begin
                  we_s    = WE0_i;
                  addr_s  = ADDR0_i;
                  wdata_s = WDATA0_i;
               end
               state_s = ST_SETUP;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SETUP: begin
            cnt_s   = CNT_LOAD;
            state_s = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (cnt_r == CNT_ZERO) begin
               // Last ACCESS edge: sample read data and raise ACK for HOLD.
               state_s = ST_HOLD;
               if (port_r) begin
                  ack1_s = 1'b1;
               end else begin
                  ack0_s = 1'b1;
               end
               if (!we_r && port_r) begin
                  rdata1_s = SRAM_DQ_i;
               end else if (!we_r) begin
                  rdata0_s = SRAM_DQ_i;
               end else begin
                  rdata0_s = rdata0_r;
                  rdata1_s = rdata1_r;
               end
            end else begin
               cnt_s   = cnt_r - CNT_ONE;
               state_s = ST_ACCESS;
            end
         end
         ST_HOLD: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase

      // Strobes follow the state being entered. IDLE always separates two
      // accesses, so DQ_OE and a low OE_N never overlap.
      ce_n_s  = 1'b1;
      we_n_s  = 1'b1;
      oe_n_s  = 1'b1;
      dq_oe_s = 1'b0;
      case (state_s)
         ST_SETUP: begin
            ce_n_s  = 1'b0;
            oe_n_s  = we_s;
            dq_oe_s = we_s;
         end
         ST_ACCESS: begin
            ce_n_s  = 1'b0;
            we_n_s  = ~we_s;
            oe_n_s  = we_s;
            dq_oe_s = we_s;
         end
         ST_HOLD: begin
            // Keep ADDR and write data driven for hold time.
            ce_n_s  = 1'b0;
            dq_oe_s = we_s;
         end
         ST_IDLE: begin
            ce_n_s  = 1'b1;
            dq_oe_s = 1'b0;
         end
         default: begin
            ce_n_s  = 1'b1;
            dq_oe_s = 1'b0;
         end
      endcase
   end

   // Datapath and output registers. Reset parks the strobes inactive at once.
   always_ff @(posedge CLK_IN or posedge RST_IN) begin
      if (RST_IN) begin
         cnt_r    <= CNT_ZERO;
         port_r   <= 1'b0;
         we_r     <= 1'b0;
         addr_r   <= {ADDR_W{1'b0}};
         wdata_r  <= {DATA_W{1'b0}};
         ack0_r   <= 1'b0;
         ack1_r   <= 1'b0;
         rdata0_r <= {DATA_W{1'b0}};
         rdata1_r <= {DATA_W{1'b0}};
         ce_n_r   <= 1'b1;
         we_n_r   <= 1'b1;
         oe_n_r   <= 1'b1;
         dq_oe_r  <= 1'b0;
      end else begin
         cnt_r    <= cnt_s;
         port_r   <= port_s;
         we_r     <= we_s;
         addr_r   <= addr_s;
         wdata_r  <= wdata_s;
         ack0_r   <= ack0_s;
         ack1_r   <= ack1_s;
         rdata0_r <= rdata0_s;
         rdata1_r <= rdata1_s;
         ce_n_r   <= ce_n_s;
         we_n_r   <= we_n_s;
         oe_n_r   <= oe_n_s;
         dq_oe_r  <= dq_oe_s;
      end
   end

   assign ACK0_o       = ack0_r;
   assign ACK1_o       = ack1_r;
   assign RDATA0_o     = rdata0_r;
   assign RDATA1_o     = rdata1_r;
   assign SRAM_ADDR_o  = addr_r;
   assign SRAM_DQ_o    = wdata_r;
   assign SRAM_DQ_OE_o = dq_oe_r;
   assign SRAM_CE_N_o  = ce_n_r;
   assign SRAM_WE_N_o  = we_n_r;
   assign SRAM_OE_N_o  = oe_n_r;

endmodule
